// File: rtl/connect_argmax_pkg.sv
// Shared types and helpers for the classifier argmax back end.
package connect_argmax_pkg;
   localparam int SCORE_W = 8;

   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

   // Strictly-greater signed compare; ties must not replace the incumbent.
   function automatic logic score_gt(input logic signed [SCORE_W-1:0] a,
                                     input logic signed [SCORE_W-1:0] b);
      return a > b;
   endfunction
endpackage

// File: rtl/connect_argmax_if.sv
// Score stream, control, readback and result bus of the argmax block.
interface connect_argmax_if
   import connect_argmax_pkg::*;
   #(parameter int NUM_CLASS = 10, parameter int IDX_W = 4);
   logic                       in_vld;
   logic signed [SCORE_W-1:0]  score;
   logic                       clear;
   logic [IDX_W-1:0]           rd_idx;
   logic signed [SCORE_W-1:0]  rd_score;
   logic [IDX_W-1:0]           class_idx;
   logic signed [SCORE_W-1:0]  max_score;
   logic                       out_vld;
   logic                       busy;

   modport master (output in_vld, score, clear, rd_idx,
                   input  rd_score, class_idx, max_score, out_vld, busy);
   modport slave  (input  in_vld, score, clear, rd_idx,
                   output rd_score, class_idx, max_score, out_vld, busy);
endinterface

// File: rtl/connect_argmax_bank.sv
// Per-class score register file: one write port, one combinational read port.
module connect_argmax_bank
   import connect_argmax_pkg::*;
   #(parameter int NUM_CLASS = 10, parameter int IDX_W = 4)
   (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_we,
   input  logic [IDX_W-1:0]          i_waddr,
   input  logic signed [SCORE_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]          i_raddr,
   output logic signed [SCORE_W-1:0] o_rdata
   );
   localparam logic [IDX_W:0] NC = (IDX_W+1)'(NUM_CLASS);

   logic [NUM_CLASS-1:0][SCORE_W-1:0] r_mem;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Addresses past the last class read as zero rather than aliasing.
   always_comb begin
      o_rdata = '0;
      if ({1'b0, i_raddr} < NC) o_rdata = r_mem[i_raddr];
   end
endmodule

// File: rtl/connect_argmax.sv
// Running-max classifier: tracks the winning class over a NUM_CLASS-score frame.
module connect_argmax
   import connect_argmax_pkg::*;
   #(parameter int NUM_CLASS = 10, parameter int IDX_W = 4)
   (
   input  logic             clk,
   input  logic             rst_n,
   connect_argmax_if.slave  bus
   );
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASS - 1);

   state_t                     r_state, w_state_nxt;
   logic [IDX_W-1:0]           r_cnt;
   logic signed [SCORE_W-1:0]  r_run_max;
   logic [IDX_W-1:0]           r_run_idx;
   logic [IDX_W-1:0]           r_class_idx;
   logic signed [SCORE_W-1:0]  r_max_score;
   logic                       r_out_vld;

   logic                       w_acc, w_last, w_take;
   logic signed [SCORE_W-1:0]  w_new_max;
   logic [IDX_W-1:0]           w_new_idx;

   assign w_acc  = bus.in_vld & ~bus.clear;
   assign w_last = (r_cnt == LAST);
   // First score of a frame seeds the running max unconditionally.
   assign w_take    = (r_cnt == '0) | score_gt(bus.score, r_run_max);
   assign w_new_max = w_take ? bus.score : r_run_max;
   assign w_new_idx = w_take ? r_cnt     : r_run_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_acc) w_state_nxt = ACC;
         ACC: begin
            if (bus.clear)           w_state_nxt = IDLE;
            else if (w_acc && w_last) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_run_max   <= '0;
         r_run_idx   <= '0;
         r_class_idx <= '0;
         r_max_score <= '0;
         r_out_vld   <= 1'b0;
      end else begin
         r_out_vld <= w_acc & w_last;
         if (bus.clear) begin
            r_cnt <= '0;
         end else if (w_acc) begin
            r_run_max <= w_new_max;
            r_run_idx <= w_new_idx;
            if (w_last) begin
               r_cnt       <= '0;
               r_class_idx <= w_new_idx;
               r_max_score <= w_new_max;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   connect_argmax_bank #(.NUM_CLASS(NUM_CLASS), .IDX_W(IDX_W)) u_bank (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_we    (w_acc),
      .i_waddr (r_cnt),
      .i_wdata (bus.score),
      .i_raddr (bus.rd_idx),
      .o_rdata (bus.rd_score)
   );

   assign bus.class_idx = r_class_idx;
   assign bus.max_score = r_max_score;
   assign bus.out_vld   = r_out_vld;
   assign bus.busy      = (r_state == ACC);
endmodule

// File: tb/tb_connect_argmax.sv
// Directed + randomized bench for connect_argmax against a frame-level reference model.
module tb_connect_argmax;
   localparam int NC = 10;
   localparam int IW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   connect_argmax_if #(.NUM_CLASS(NC), .IDX_W(IW)) bus ();
   connect_argmax #(.NUM_CLASS(NC), .IDX_W(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int tests = 0;
   int fails = 0;
   int q[$];          // scores accepted so far in the current frame
   int mb[NC];        // expected bank contents
   int exp_idx = 0, exp_max = 0, exp_vld = 0;
   int pulses = 0;
   int fr[NC];

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive, let the edge happen, then compare against the model.
   task automatic tick(input logic v, input int sc, input logic c);
      int best, bi;
      bus.in_vld = v; bus.score = sc[7:0]; bus.clear = c;
      @(negedge clk);
      exp_vld = 0;
      if (c) q.delete();
      else if (v) begin
         mb[q.size()] = sc;
         q.push_back(sc);
         if (q.size() == NC) begin
            best = q[0]; bi = 0;
            foreach (q[i]) if (q[i] > best) begin best = q[i]; bi = i; end
            exp_idx = bi; exp_max = best; exp_vld = 1;
            q.delete();
         end
      end
      if (bus.out_vld) pulses++;
      chk("out_vld", int'(bus.out_vld), exp_vld);
      chk("busy", int'(bus.busy), int'(q.size() != 0));
      chk("class_idx", int'(bus.class_idx), exp_idx);
      chk("max_score", int'(bus.max_score), exp_max);
   endtask

   task automatic send_frame(input int gap_max);
      for (int i = 0; i < NC; i++) begin
         tick(1'b1, fr[i], 1'b0);
         if (i != NC - 1)
            repeat ($urandom_range(gap_max, 0)) tick(1'b0, 0, 1'b0);
      end
   endtask

   task automatic rand_frame(input int lo, input int hi);
      for (int i = 0; i < NC; i++) fr[i] = int'($urandom_range(hi - lo, 0)) + lo;
   endtask

   task automatic rd_chk(input int i);
      bus.rd_idx = i[IW-1:0];
      #1;
      chk("rd_score", int'(bus.rd_score), (i < NC) ? mb[i] : 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      bus.in_vld = 0; bus.score = 0; bus.clear = 0; bus.rd_idx = 0;
      foreach (mb[i]) mb[i] = 0;
      repeat (2) @(negedge clk);
      chk("rst_out_vld", int'(bus.out_vld), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_class_idx", int'(bus.class_idx), 0);
      chk("rst_max_score", int'(bus.max_score), 0);
      rd_chk(3);
      rst_n = 1'b1;

      // Tie at index 5 must lose to index 3.
      fr = '{0, 5, -3, 12, 7, 12, -128, 1, 2, 3};
      send_frame(0);
      tick(1'b0, 0, 1'b0);
      chk("tie_idx", exp_idx, 3);
      chk("tie_max", exp_max, 12);
      foreach (fr[i]) fr[i] = -128;
      send_frame(0);
      tick(1'b0, 0, 1'b0);
      foreach (fr[i]) fr[i] = 127;
      send_frame(0);
      tick(1'b0, 0, 1'b0);
      foreach (fr[i]) fr[i] = -1;
      fr[9] = 127;
      send_frame(0);
      tick(1'b0, 0, 1'b0);

      // Partial frame aborted by clear with a simultaneous valid score.
      for (int i = 0; i < 4; i++) tick(1'b1, int'($urandom_range(100, 0)) - 50, 1'b0);
      tick(1'b1, 99, 1'b1);
      rd_chk(4);
      rand_frame(-128, 90);
      fr[6] = 100;
      p0 = pulses;
      send_frame(0);
      tick(1'b0, 0, 1'b0);
      chk("clear_pulses", pulses - p0, 1);

      // Back-to-back frames, second with winner at index 1.
      rand_frame(-128, 127);
      p0 = pulses;
      send_frame(0);
      rand_frame(-128, 60);
      fr[1] = 61 + int'($urandom_range(66, 0));
      send_frame(0);
      tick(1'b0, 0, 1'b0);
      chk("b2b_pulses", pulses - p0, 2);

      // Same frame gapless then with random gaps, followed by readback.
      rand_frame(-128, 127);
      send_frame(0);
      send_frame(3);
      tick(1'b0, 0, 1'b0);
      for (int i = 0; i < NC; i++) rd_chk(i);
      rd_chk(12);

      // Asynchronous reset mid-frame.
      for (int i = 0; i < 5; i++) tick(1'b1, int'($urandom_range(255, 0)) - 128, 1'b0);
      bus.in_vld = 0;
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      foreach (mb[i]) mb[i] = 0;
      exp_idx = 0; exp_max = 0;
      chk("arst_out_vld", int'(bus.out_vld), 0);
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_class_idx", int'(bus.class_idx), 0);
      chk("arst_max_score", int'(bus.max_score), 0);
      rd_chk(2);
      @(negedge clk);
      rst_n = 1'b1;
      rand_frame(-128, -10);
      send_frame(2);
      tick(1'b0, 0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         rand_frame(-128, 127);
         send_frame(k % 3);
      end
      tick(1'b0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
